// File: rtl/mmio_timer_pkg.sv
// Shared bus command encodings, timer register offsets and CTRL bit indices
// for the mmio_timer peripheral and the neighbouring I/O blocks.
package mmio_timer_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b11;

  localparam logic [2:0] OFS_LOAD   = 3'd0;
  localparam logic [2:0] OFS_COUNT  = 3'd1;
  localparam logic [2:0] OFS_CTRL   = 3'd2;
  localparam logic [2:0] OFS_STATUS = 3'd3;
  localparam logic [2:0] OFS_PSC    = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts 0..term while enabled and pulses tick on the
// terminal cycle; clear restarts the count from 0.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] term,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = 16'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer (LOAD/COUNT/CTRL/STATUS) on the shared bus.
// Define MMIO_TIMER_PRESCALE_RW_EN to add a writable PSC register at +4.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [8:0]  BASE_ADDR = 9'h180,
  parameter logic [15:0] PRESCALE  = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] w_data,
  output logic [15:0] r_data,
  output logic        rd_hit,
  output logic        expired
);

`ifdef MMIO_TIMER_PRESCALE_RW_EN
  localparam logic [8:0] NWORDS = 9'd5;
`else
  localparam logic [8:0] NWORDS = 9'd4;
`endif

  logic [8:0]  ofs;
  logic        in_win, wr_en;
  logic        wr_load, wr_ctrl, wr_status, wr_psc;
  logic [15:0] load_q, load_d, count_q, count_d;
  logic        en_q, en_d, auto_q, auto_d, exp_q, exp_d, exp_set;
  logic        tick, psc_clear;
  logic [15:0] term, rd_word;

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign ofs       = mem_addr - BASE_ADDR;
  assign in_win    = ofs < NWORDS;
  assign wr_en     = (mem_cmd == MWRITE) && in_win;
  assign wr_load   = wr_en && (ofs[2:0] == OFS_LOAD);
  assign wr_ctrl   = wr_en && (ofs[2:0] == OFS_CTRL);
  assign wr_status = wr_en && (ofs[2:0] == OFS_STATUS);

`ifdef MMIO_TIMER_PRESCALE_RW_EN
  logic [15:0] psc_q;
  assign wr_psc = wr_en && (ofs[2:0] == OFS_PSC);
  assign term   = psc_q - 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q <= PRESCALE;
    end else if (wr_psc) begin
      psc_q <= (w_data == 16'd0) ? 16'd1 : w_data;
    end
  end
`else
  assign wr_psc = 1'b0;
  assign term   = PRESCALE - 16'd1;
`endif

  assign psc_clear = wr_load || wr_psc || (wr_ctrl && w_data[CTRL_EN] && !en_q);

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (en_q),
    .clear  (psc_clear),
    .term   (term),
    .tick   (tick)
  );

  // A LOAD write in a tick cycle overrides both the decrement and the expiry.
  assign exp_set = tick && !wr_load && (count_q == 16'd1);

  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    exp_d   = exp_q;
    if (wr_ctrl) begin
      en_d   = w_data[CTRL_EN];
      auto_d = w_data[CTRL_AUTO];
    end
    if (wr_load) begin
      load_d  = w_data;
      count_d = w_data;
    end else if (tick) begin
      if (count_q == 16'd1) begin
        count_d = auto_q ? load_q : 16'd0;
      end else if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end
    end
    if (wr_status && w_data[0]) begin
      exp_d = 1'b0;
    end
    if (exp_set) begin
      exp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q  <= 16'd0;
      count_q <= 16'd0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    rd_word = 16'd0;
    case (ofs[2:0])
      OFS_LOAD:   rd_word = load_q;
      OFS_COUNT:  rd_word = count_q;
      OFS_CTRL: begin
        rd_word[CTRL_EN]   = en_q;
        rd_word[CTRL_AUTO] = auto_q;
      end
      OFS_STATUS: rd_word[0] = exp_q;
`ifdef MMIO_TIMER_PRESCALE_RW_EN
      OFS_PSC:    rd_word = psc_q;
`endif
      default:    rd_word = 16'd0;
    endcase
  end

  assign rd_hit  = (mem_cmd == MREAD) && in_win;
  assign r_data  = rd_hit ? rd_word : 16'bz;
  assign expired = exp_q;

endmodule
